game_collision_scanner: RTL and testbench
=========================================

GAME_COLLISION_SCANNER -- requirements
Module: game_collision_scanner

Interface
REQ-001 SHALL have parameter N_TARGETS, default `N_TARGETS (game_config.svh), number of targets; legal values are 2 and above.
REQ-002 SHALL have parameter W_X, default $clog2(640), x coordinate width.
REQ-003 SHALL have parameter W_Y, default $clog2(480), y coordinate width.
REQ-004 SHALL have parameter IMM_W, default 3, immunity counter width.
REQ-005 SHALL have parameter IMM_SCANS, default 3, immunity length in scans; legal range is 1 to 2**IMM_W-1.
REQ-006 SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle request to start a scan.
REQ-009 SHALL have port enable_targets, input, N_TARGETS, per-target enable.
REQ-010 SHALL have ports sprite_left and sprite_right, input, [N_TARGETS][W_X], bounding-box x edges.
REQ-011 SHALL have ports sprite_top and sprite_bottom, input, [N_TARGETS][W_Y], bounding-box y edges.
REQ-012 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-013 SHALL have port done, output, 1, single-cycle pulse when scan results are valid.
REQ-014 SHALL have ports collide_x and collide_y, output, N_TARGETS each, per-target collision flags.
REQ-015 SHALL have port collision_count, output, $clog2(P+1), number of new collisions in the last scan, where P = N_TARGETS*(N_TARGETS-1)/2.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-017 SHALL, in IDLE on start=1, capture all bounds and enable_targets into shadow registers, clear the result accumulators, and enter SCAN.
REQ-018 SHALL ignore start while busy (SCAN or DONE); no queuing.
REQ-019 SHALL, in SCAN, visit exactly one pair (i<j) per cycle in order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1), taking P cycles.
REQ-020 SHALL define overlap as (L_i<R_j)&&(R_i>L_j)&&(T_i<B_j)&&(B_i>T_j), using unsigned strict comparisons.
REQ-021 SHALL, per visited pair with immunity counter c!=0, decrement c by 1 and report no collision, regardless of enables or overlap.
REQ-022 SHALL, per visited pair with c==0 where both targets are enabled and overlap holds, set c=IMM_SCANS, OR the collision flags into both targets, and increment the count.
REQ-023 SHALL therefore suppress a given pair's collision for exactly IMM_SCANS subsequent scans.
REQ-024 SHALL enter DONE after the last pair, pulse done for 1 cycle, and load collide_x, collide_y and collision_count from the accumulators in that same cycle, then return to IDLE.
REQ-025 SHALL have latency of done = start cycle + P + 1 cycles; start is accepted again on the cycle after done.
REQ-026 SHALL hold collide_x, collide_y and collision_count stable between done pulses.
REQ-027 SHALL keep busy=1 in SCAN and DONE, and busy=0 in IDLE.
REQ-028 SHALL make input changes during a scan have no effect on that scan (shadow copy only).

Reset
REQ-029 SHALL, on rst, asynchronously force the FSM to IDLE and set busy=0, done=0, collide_x=0, collide_y=0, collision_count=0, all immunity counters=0 and all accumulators=0.
REQ-030 SHALL, on rst mid-scan, abort the scan with no done pulse and leave no partial results visible.

Configuration
REQ-031 SHALL, with GAME_COLLISION_AXIS_RESOLVE_EN defined, compute dx=min(R_i,R_j)-max(L_i,L_j) and dy=min(B_i,B_j)-max(T_i,T_j) per collision, and flag x only if dx<dy, y only if dy<dx, and both if equal.
REQ-032 SHALL, without GAME_COLLISION_AXIS_RESOLVE_EN, set both collide_x and collide_y for every colliding target, with no depth logic synthesised.

Structure
REQ-033 SHALL place the state enum, function num_pairs(n) and the immunity counter typedef in package game_collision_pkg.
REQ-034 SHALL implement overlap and depth computation in combinational sub-module game_pair_overlap, instanced once on the current pair's shadow bounds.

Verification (N_TARGETS=4, IMM_SCANS=3, P=6)
REQ-035 SHALL verify: T0=[10,30)x[10,30) and T1=[20,40)x[10,30), all enabled, start -> done 7 cycles later, collide_x=4'b0011, count=1; with the macro, collide_y=0 (dx=10<dy=20).
REQ-036 SHALL verify: the same boxes rescanned 4 times -> scans 2-4 report count=0 and flags 0, and scan 5 reports the collision again.
REQ-037 SHALL verify: touching edges (R0=20, L1=20) -> no collision; disabling T1 while overlapping -> no collision.
REQ-038 SHALL verify: start pulsed at scan cycles 2 and 7 (DONE) -> both ignored, a single done pulse, busy low for 1 cycle before any new accept.
REQ-039 SHALL verify: rst asserted at scan cycle 3 -> no done, outputs 0, and the next scan with the same overlap reports a collision (counters cleared).
REQ-040 SHALL verify: T0-T1 and T2-T3 overlapping with equal depths -> collide_x=collide_y=4'b1111 and count=2.

Source files
------------

// File: rtl/game_collision_pkg.sv
// Shared types and helpers for the collision scanner: FSM state encoding,
// pair-count function and the default immunity counter type.
package game_collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    localparam int IMM_W_DEFAULT = 3;
    typedef logic [IMM_W_DEFAULT-1:0] imm_cnt_t;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/game_pair_overlap.sv
// Combinational box-overlap test for one target pair (a, b).
// With GAME_COLLISION_AXIS_RESOLVE_EN the shallower penetration axis selects the flags.
module game_pair_overlap #(
    parameter int W_X = 10,
    parameter int W_Y = 9
) (
    input  logic [W_X-1:0] i_l_a,
    input  logic [W_X-1:0] i_r_a,
    input  logic [W_Y-1:0] i_t_a,
    input  logic [W_Y-1:0] i_b_a,
    input  logic [W_X-1:0] i_l_b,
    input  logic [W_X-1:0] i_r_b,
    input  logic [W_Y-1:0] i_t_b,
    input  logic [W_Y-1:0] i_b_b,
    output logic           o_overlap,
    output logic           o_flag_x,
    output logic           o_flag_y
);

    // Edges that merely touch do not overlap: all comparisons are strict.
    assign o_overlap = (i_l_a < i_r_b) && (i_r_a > i_l_b) &&
                       (i_t_a < i_b_b) && (i_b_a > i_t_b);

`ifdef GAME_COLLISION_AXIS_RESOLVE_EN
    localparam int W_D = (W_X > W_Y) ? W_X : W_Y;

    logic [W_X-1:0] w_min_r;
    logic [W_X-1:0] w_max_l;
    logic [W_Y-1:0] w_min_b;
    logic [W_Y-1:0] w_max_t;
    logic [W_D-1:0] w_dx;
    logic [W_D-1:0] w_dy;

    always_comb begin
        w_min_r  = (i_r_a < i_r_b) ? i_r_a : i_r_b;
        w_max_l  = (i_l_a > i_l_b) ? i_l_a : i_l_b;
        w_min_b  = (i_b_a < i_b_b) ? i_b_a : i_b_b;
        w_max_t  = (i_t_a > i_t_b) ? i_t_a : i_t_b;
        // Depths are only meaningful (non-negative) when o_overlap holds.
        w_dx     = W_D'(w_min_r - w_max_l);
        w_dy     = W_D'(w_min_b - w_max_t);
        o_flag_x = (w_dx <= w_dy);
        o_flag_y = (w_dy <= w_dx);
    end
`else
    assign o_flag_x = 1'b1;
    assign o_flag_y = 1'b1;
`endif

endmodule

// File: rtl/game_collision_scanner.sv
// Sequential pairwise bounding-box collision scanner with per-pair immunity.
// Optional axis resolution via the GAME_COLLISION_AXIS_RESOLVE_EN macro.
`ifndef N_TARGETS
`define N_TARGETS 4
`endif

module game_collision_scanner
    import game_collision_pkg::*;
#(
    parameter int N_TARGETS = `N_TARGETS,
    parameter int W_X       = $clog2(640),
    parameter int W_Y       = $clog2(480),
    parameter int IMM_W     = $bits(imm_cnt_t),
    parameter int IMM_SCANS = 3,
    localparam int P        = num_pairs(N_TARGETS),
    localparam int CNT_W    = $clog2(P + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N_TARGETS-1:0]          enable_targets,
    input  logic [N_TARGETS-1:0][W_X-1:0] sprite_left,
    input  logic [N_TARGETS-1:0][W_X-1:0] sprite_right,
    input  logic [N_TARGETS-1:0][W_Y-1:0] sprite_top,
    input  logic [N_TARGETS-1:0][W_Y-1:0] sprite_bottom,
    output logic                          busy,
    output logic                          done,
    output logic [N_TARGETS-1:0]          collide_x,
    output logic [N_TARGETS-1:0]          collide_y,
    output logic [CNT_W-1:0]              collision_count,
    output logic [1:0]                    dbg_state
);

    localparam int IDX_W  = $clog2(N_TARGETS);
    localparam int PAIR_W = (P > 1) ? $clog2(P) : 1;

    scan_state_t r_state;
    scan_state_t w_next_state;

    logic [N_TARGETS-1:0]          r_en;
    logic [N_TARGETS-1:0][W_X-1:0] r_left;
    logic [N_TARGETS-1:0][W_X-1:0] r_right;
    logic [N_TARGETS-1:0][W_Y-1:0] r_top;
    logic [N_TARGETS-1:0][W_Y-1:0] r_bottom;
    logic [IDX_W-1:0]              r_i;
    logic [IDX_W-1:0]              r_j;
    logic [PAIR_W-1:0]             r_pair;
    logic [IMM_W-1:0]              r_imm [P];
    logic [N_TARGETS-1:0]          r_acc_x;
    logic [N_TARGETS-1:0]          r_acc_y;
    logic [CNT_W-1:0]              r_acc_cnt;

    logic                 w_overlap;
    logic                 w_flag_x;
    logic                 w_flag_y;
    logic                 w_last;
    logic                 w_hit;
    logic [IMM_W-1:0]     w_imm_cur;
    logic [N_TARGETS-1:0] w_add_x;
    logic [N_TARGETS-1:0] w_add_y;
    logic [CNT_W-1:0]     w_cnt_next;

    game_pair_overlap #(
        .W_X (W_X),
        .W_Y (W_Y)
    ) u_pair_overlap (
        .i_l_a     (r_left[r_i]),
        .i_r_a     (r_right[r_i]),
        .i_t_a     (r_top[r_i]),
        .i_b_a     (r_bottom[r_i]),
        .i_l_b     (r_left[r_j]),
        .i_r_b     (r_right[r_j]),
        .i_t_b     (r_top[r_j]),
        .i_b_b     (r_bottom[r_j]),
        .o_overlap (w_overlap),
        .o_flag_x  (w_flag_x),
        .o_flag_y  (w_flag_y)
    );

    assign w_last    = (r_pair == PAIR_W'(P - 1));
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_SCAN;
            ST_SCAN: if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A pair still under immunity is silenced regardless of overlap or enables.
    always_comb begin
        w_imm_cur = r_imm[r_pair];
        w_hit     = (w_imm_cur == '0) && r_en[r_i] && r_en[r_j] && w_overlap;
        w_add_x   = '0;
        w_add_y   = '0;
        if (w_hit && w_flag_x) begin
            w_add_x[r_i] = 1'b1;
            w_add_x[r_j] = 1'b1;
        end
        if (w_hit && w_flag_y) begin
            w_add_y[r_i] = 1'b1;
            w_add_y[r_j] = 1'b1;
        end
        w_cnt_next = r_acc_cnt + CNT_W'(w_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en            <= '0;
            r_left          <= '0;
            r_right         <= '0;
            r_top           <= '0;
            r_bottom        <= '0;
            r_i             <= '0;
            r_j             <= '0;
            r_pair          <= '0;
            r_acc_x         <= '0;
            r_acc_y         <= '0;
            r_acc_cnt       <= '0;
            collide_x       <= '0;
            collide_y       <= '0;
            collision_count <= '0;
            for (int p = 0; p < P; p++) r_imm[p] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_en      <= enable_targets;
                        r_left    <= sprite_left;
                        r_right   <= sprite_right;
                        r_top     <= sprite_top;
                        r_bottom  <= sprite_bottom;
                        r_i       <= '0;
                        r_j       <= IDX_W'(1);
                        r_pair    <= '0;
                        r_acc_x   <= '0;
                        r_acc_y   <= '0;
                        r_acc_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_imm_cur != '0)
                        r_imm[r_pair] <= w_imm_cur - 1'b1;
                    else if (w_hit)
                        r_imm[r_pair] <= IMM_W'(IMM_SCANS);
                    r_acc_x   <= r_acc_x | w_add_x;
                    r_acc_y   <= r_acc_y | w_add_y;
                    r_acc_cnt <= w_cnt_next;
                    r_pair    <= r_pair + 1'b1;
                    // Results land together with the last pair so they are valid during done.
                    if (w_last) begin
                        collide_x       <= r_acc_x | w_add_x;
                        collide_y       <= r_acc_y | w_add_y;
                        collision_count <= w_cnt_next;
                    end else if (r_j == IDX_W'(N_TARGETS - 1)) begin
                        r_i <= r_i + 1'b1;
                        r_j <= r_i + IDX_W'(2);
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_collision_scanner.sv
// Directed self-checking bench for game_collision_scanner (N_TARGETS=4, IMM_SCANS=3).
// Expected axis flags follow GAME_COLLISION_AXIS_RESOLVE_EN when it is defined.
module tb_game_collision_scanner;

    localparam int N  = 4;
    localparam int WX = 10;
    localparam int WY = 9;
    localparam int CW = 3;
    localparam logic [16:0] BUSY_NORMAL = 17'h000FE;

`ifdef GAME_COLLISION_AXIS_RESOLVE_EN
    localparam logic [3:0] EXP_Y_WIDE = 4'b0000;
    localparam logic [3:0] EXP_X_TALL = 4'b0000;
`else
    localparam logic [3:0] EXP_Y_WIDE = 4'b0011;
    localparam logic [3:0] EXP_X_TALL = 4'b0011;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [N-1:0]         enable_targets;
    logic [N-1:0][WX-1:0] sprite_left;
    logic [N-1:0][WX-1:0] sprite_right;
    logic [N-1:0][WY-1:0] sprite_top;
    logic [N-1:0][WY-1:0] sprite_bottom;
    logic                 busy;
    logic                 done;
    logic [N-1:0]         collide_x;
    logic [N-1:0]         collide_y;
    logic [CW-1:0]        collision_count;
    logic [1:0]           dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int n_done;
    logic [16:0] btr;

    game_collision_scanner #(
        .N_TARGETS (N),
        .W_X       (WX),
        .W_Y       (WY),
        .IMM_W     (3),
        .IMM_SCANS (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .enable_targets  (enable_targets),
        .sprite_left     (sprite_left),
        .sprite_right    (sprite_right),
        .sprite_top      (sprite_top),
        .sprite_bottom   (sprite_bottom),
        .busy            (busy),
        .done            (done),
        .collide_x       (collide_x),
        .collide_y       (collide_y),
        .collision_count (collision_count),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_box(input int k, input int l, input int r, input int t, input int b);
        sprite_left[k]   = WX'(l);
        sprite_right[k]  = WX'(r);
        sprite_top[k]    = WY'(t);
        sprite_bottom[k] = WY'(b);
    endtask

    // T0 and T1 overlap (dx=10, dy=20); T2, T3 are far from everything.
    task automatic default_boxes();
        set_box(0, 10, 30, 10, 30);
        set_box(1, 20, 40, 10, 30);
        set_box(2, 200, 210, 200, 210);
        set_box(3, 300, 310, 300, 310);
        enable_targets = 4'hF;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle 0 carries start; cycles 1..16 are sampled, with optional extra
    // start pulses, a reset pulse and an input mutation at chosen cycles.
    task automatic run_scan(input int pa, input int pb, input int rst_at, input int mut_at,
                            output int o_lat, output int o_ndone, output logic [16:0] o_btr);
        @(negedge clk);
        start   = 1'b1;
        o_lat   = 0;
        o_ndone = 0;
        o_btr   = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            o_btr[k] = busy;
            if (done) begin
                o_ndone++;
                if (o_lat == 0) o_lat = k;
            end
            start = (k == pa) || (k == pb);
            rst   = (k == rst_at);
            if (k == mut_at) begin
                enable_targets = '0;
                sprite_left[1] = WX'(900);
            end
        end
    endtask

    task automatic scan_plain();
        run_scan(0, 0, 0, 0, lat, n_done, btr);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        default_boxes();
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_cx", collide_x, 0);
        check("reset_cy", collide_y, 0);
        check("reset_cnt", collision_count, 0);
        check("reset_state", dbg_state, 0);
        rst = 1'b0;

        // Basic overlap and latency
        scan_plain();
        check("s1_latency", lat, 7);
        check("s1_ndone", n_done, 1);
        check("s1_busy_trace", btr, BUSY_NORMAL);
        check("s1_cx", collide_x, 4'b0011);
        check("s1_cy", collide_y, EXP_Y_WIDE);
        check("s1_cnt", collision_count, 1);

        // Immunity: three silent scans, then the collision returns
        for (int s = 2; s <= 4; s++) begin
            scan_plain();
            check($sformatf("s%0d_cnt", s), collision_count, 0);
            check($sformatf("s%0d_cx", s), collide_x, 0);
            check($sformatf("s%0d_cy", s), collide_y, 0);
        end
        scan_plain();
        check("s5_cnt", collision_count, 1);
        check("s5_cx", collide_x, 4'b0011);

        // Outputs hold between done pulses even as inputs move
        repeat (4) @(negedge clk);
        sprite_left[1] = WX'(900);
        enable_targets = 4'h0;
        @(negedge clk);
        check("hold_cx", collide_x, 4'b0011);
        check("hold_cnt", collision_count, 1);

        // Touching edges and disabled target
        do_reset();
        default_boxes();
        set_box(0, 10, 20, 10, 30);
        scan_plain();
        check("touch_cnt", collision_count, 0);
        check("touch_cx", collide_x, 0);
        set_box(0, 10, 30, 10, 30);
        enable_targets = 4'b1101;
        scan_plain();
        check("disabled_cnt", collision_count, 0);
        check("disabled_cy", collide_y, 0);
        enable_targets = 4'hF;
        scan_plain();
        check("reenabled_cnt", collision_count, 1);

        // Start while busy is ignored; inputs changed mid-scan have no effect
        do_reset();
        default_boxes();
        run_scan(2, 7, 0, 2, lat, n_done, btr);
        check("busy_start_ndone", n_done, 1);
        check("busy_start_latency", lat, 7);
        check("busy_start_trace", btr, BUSY_NORMAL);
        check("shadow_cnt", collision_count, 1);
        check("shadow_cx", collide_x, 4'b0011);

        // Reset mid-scan aborts and clears immunity
        do_reset();
        default_boxes();
        scan_plain();
        check("prerst_cnt", collision_count, 1);
        run_scan(0, 0, 3, 0, lat, n_done, btr);
        check("midrst_ndone", n_done, 0);
        check("midrst_cx", collide_x, 0);
        check("midrst_cy", collide_y, 0);
        check("midrst_cnt", collision_count, 0);
        check("midrst_busy", busy, 0);
        scan_plain();
        check("postrst_latency", lat, 7);
        check("postrst_cnt", collision_count, 1);
        check("postrst_cx", collide_x, 4'b0011);

        // Two pairs with equal depths
        do_reset();
        default_boxes();
        set_box(1, 20, 40, 20, 40);
        set_box(2, 200, 220, 200, 220);
        set_box(3, 210, 230, 210, 230);
        scan_plain();
        check("equal_cx", collide_x, 4'b1111);
        check("equal_cy", collide_y, 4'b1111);
        check("equal_cnt", collision_count, 2);

        // Vertical overlap shallower than horizontal (dx=20, dy=5)
        do_reset();
        default_boxes();
        set_box(1, 10, 30, 25, 45);
        scan_plain();
        check("tall_cx", collide_x, EXP_X_TALL);
        check("tall_cy", collide_y, 4'b0011);
        check("tall_cnt", collision_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
